// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory among NREQ requesters.
// A registered owner FSM grants one access per cycle, with bounded bursts while others wait.
module dmem_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we_in,
  input  logic [NREQ*32-1:0]   addr_in,
  input  logic [NREQ*32-1:0]   wdata_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [31:0]          rdata_out,
  output logic                 mem_we,
  output logic [31:0]          mem_a,
  output logic [31:0]          mem_wd,
  input  logic [31:0]          mem_rd
);

  localparam int unsigned OwW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [OwW-1:0]    owner_q, owner_d;
  logic [OwW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   burst_q, burst_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       addr_arr  [NREQ];
  logic [31:0]       wdata_arr [NREQ];
  logic [NREQ-1:0]   owner_oh;
  logic [NREQ-1:0]   others;
  logic [OwW:0]      pick_all;
  logic [OwW:0]      pick_oth;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = addr_in[32*i +: 32];
    assign wdata_arr[i] = wdata_in[32*i +: 32];
  end

  // Returns {found, index} of the first set mask bit scanning start, start+1, ... mod NREQ.
  function automatic logic [OwW:0] pick(input logic [NREQ-1:0] mask,
                                        input logic [OwW-1:0]  start);
    logic [OwW:0]    res;
    logic [NREQ-1:0] sh;
    int              idx;
    res = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % int'(NREQ);
      sh  = mask >> idx;
      if (sh[0]) res = {1'b1, OwW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [OwW-1:0] next_ptr(input logic [OwW-1:0] o);
    return OwW'((int'(o) + 1) % int'(NREQ));
  endfunction

  assign owner_oh = NREQ'(1) << owner_q;
  assign others   = req & ~owner_oh;
  assign pick_all = pick(req, rr_ptr_q);
  assign pick_oth = pick(others, rr_ptr_q);

  // Grants are suppressed outright while reset is asserted.
  assign gnt       = (state_q == StBusy && !reset) ? (req & owner_oh) : '0;
  assign mem_we    = |(gnt & we_in);
  assign mem_a     = addr_arr[owner_q];
  assign mem_wd    = wdata_arr[owner_q];
  assign rvalid    = rvalid_q;
  assign rdata_out = rdata_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    unique case (state_q)
      StIdle: begin
        if (pick_all[OwW]) begin
          state_d  = StBusy;
          owner_d  = pick_all[OwW-1:0];
          rr_ptr_d = next_ptr(pick_all[OwW-1:0]);
          burst_d  = '0;
        end
      end
      StBusy: begin
        if (!req[owner_q]) begin
          // Owner released: re-arbitrate over everyone in the same cycle.
          if (pick_all[OwW]) begin
            owner_d  = pick_all[OwW-1:0];
            rr_ptr_d = next_ptr(pick_all[OwW-1:0]);
            burst_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (|others && burst_q == BurstLast) begin
          owner_d  = pick_oth[OwW-1:0];
          rr_ptr_d = next_ptr(pick_oth[OwW-1:0]);
          burst_d  = '0;
        end else if (burst_q != BurstLast) begin
          burst_d = burst_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rvalid_d = gnt & ~we_in;
    rdata_d  = (|rvalid_d) ? mem_rd : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // A waiting requester must hold its command stable until granted.
  for (genvar i = 0; i < NREQ; i++) begin : g_stable_chk
    assert property (@(posedge clk) disable iff (reset)
      (req[i] && !gnt[i]) |=> (!req[i] || ($stable(we_in[i]) && $stable(addr_arr[i])
                                           && $stable(wdata_arr[i]))));
  end

  assert property (@(posedge clk) $onehot0(gnt));

endmodule
